// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: hold-state encoding,
// default timing for the 6 MHz system clock and counter-width helpers.
// Optional auto-repeat is enabled with `define BTN_AUTO_REPEAT_EN.
package btn_pkg;

  // Default timing constants for the 6 MHz system clock
  localparam int unsigned CLK_HZ          = 6_000_000;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned STABLE_CYC_DEF  = 32_768;
  localparam int unsigned LONG_CYC_DEF    = 6_000_000;
  localparam int unsigned REPEAT_CYC_DEF  = 1_200_000;

  // Per-channel hold state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter widths for the default timing
  localparam int unsigned DCNT_W_DEF = cnt_width(STABLE_CYC_DEF);
  localparam int unsigned HCNT_W_DEF = cnt_width(max_u(LONG_CYC_DEF, REPEAT_CYC_DEF));

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter, press/release pulses
// and the hold FSM producing long-press and (optionally) auto-repeat pulses.
// Auto-repeat is present only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYC  = STABLE_CYC_DEF,
  parameter int unsigned LONG_CYC    = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC  = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int unsigned DCNT_W = cnt_width(STABLE_CYC);
  // Hold counter sized for both periods so the channel looks the same in either build
  localparam int unsigned HCNT_W = cnt_width(max_u(LONG_CYC, REPEAT_CYC));

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(STABLE_CYC - 1);
  localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_CYC - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CYC - 1);
`else
  // Saturation value parking the counter once btn_long has fired
  localparam logic [HCNT_W-1:0] LONG_DONE = HCNT_W'(LONG_CYC);
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DCNT_W-1:0]      dcnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;
  logic                   accept;
  logic                   rise;
  logic                   fall;

  hold_state_t            state_q;
  logic [HCNT_W-1:0]      hcnt_q;
  logic                   long_q;
`ifdef BTN_AUTO_REPEAT_EN
  logic                   repeat_q;
`endif

  // Synchroniser shift chain; s is the last stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A change is accepted on the cycle the mismatch run reaches STABLE_CYC
  always_comb begin
    accept = (s != level_q) && (dcnt_q == DCNT_LAST);
    rise   = accept & s;
    fall   = accept & ~s;
  end

  // Debounce counter, debounced level and registered edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= rise;
      release_q <= fall;
      if (s == level_q) begin
        dcnt_q <= '0;
      end else if (accept) begin
        dcnt_q  <= '0;
        level_q <= s;
      end else begin
        dcnt_q <= dcnt_q + DCNT_W'(1);
      end
    end
  end

  // Hold FSM: release always wins and suppresses long/repeat in that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      long_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      long_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_q <= 1'b0;
`endif
      if (fall) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= HELD;
              hcnt_q  <= '0;
            end
          end
          HELD: begin
`ifdef BTN_AUTO_REPEAT_EN
            if (hcnt_q == LONG_LAST) begin
              long_q  <= 1'b1;
              state_q <= REPEAT;
              hcnt_q  <= '0;
            end else begin
              hcnt_q <= hcnt_q + HCNT_W'(1);
            end
`else
            if (hcnt_q == LONG_LAST) begin
              long_q <= 1'b1;
              hcnt_q <= LONG_DONE;
            end else if (hcnt_q != LONG_DONE) begin
              hcnt_q <= hcnt_q + HCNT_W'(1);
            end
`endif
          end
`ifdef BTN_AUTO_REPEAT_EN
          REPEAT: begin
            if (hcnt_q == REPEAT_LAST) begin
              repeat_q <= 1'b1;
              hcnt_q   <= '0;
            end else begin
              hcnt_q <= hcnt_q + HCNT_W'(1);
            end
          end
`endif
          default: begin
            state_q <= IDLE;
            hcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
`ifdef BTN_AUTO_REPEAT_EN
  assign btn_repeat  = repeat_q;
`else
  assign btn_repeat  = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_ext.sv
// Multi-channel button conditioner: N_BTN independent debounce channels.
// Auto-repeat pulses are generated only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_ext
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN       = 5,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYC  = STABLE_CYC_DEF,
  parameter int unsigned LONG_CYC    = LONG_CYC_DEF,
  parameter int unsigned REPEAT_CYC  = REPEAT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  // One fully independent channel per button
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CYC  (STABLE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_ext.sv
// Scoreboard bench for btn_debounce_ext with short timing constants.
module tb_btn_debounce_ext;

  localparam int N      = 5;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int LONG   = 20;
  localparam int REP    = 8;
  localparam int HLEN   = SYNC + STABLE;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;
  logic [N-1:0] btn_repeat;

  always #5 clk = ~clk;

  btn_debounce_ext #(
    .N_BTN       (N),
    .SYNC_STAGES (SYNC),
    .STABLE_CYC  (STABLE),
    .LONG_CYC    (LONG),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_repeat  (btn_repeat)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 press, 1 release, 2 long, 3 repeat
  } ev_t;

  ev_t   exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string kname[4] = '{"press", "release", "long", "repeat"};

  // Reference model state: raw-sample history, accepted level, press time
  logic [HLEN-1:0] hist [N];
  bit              mlevel [N];
  bit              held [N];
  int              press_at [N];

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Model: a change is accepted once the synchronised input has disagreed with
  // the level for STABLE consecutive samples; long/repeat are timed from the press.
  initial begin
    for (int ch = 0; ch < N; ch++) begin
      hist[ch] = '0; mlevel[ch] = 1'b0; held[ch] = 1'b0; press_at[ch] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int ch = 0; ch < N; ch++) begin
        if (rst) begin
          hist[ch] = '0; mlevel[ch] = 1'b0; held[ch] = 1'b0;
        end else begin
          bit all_diff;
          hist[ch] = {hist[ch][HLEN-2:0], btn_in[ch]};
          all_diff = 1'b1;
          for (int k = 0; k < STABLE; k++)
            if (hist[ch][SYNC+k] == mlevel[ch]) all_diff = 1'b0;
          if (all_diff) begin
            mlevel[ch] = ~mlevel[ch];
            if (mlevel[ch]) begin
              push_ev(cyc, ch, 0);
              held[ch] = 1'b1;
              press_at[ch] = cyc;
            end else begin
              push_ev(cyc, ch, 1);
              held[ch] = 1'b0;
            end
          end else if (held[ch]) begin
            int d;
            d = cyc - press_at[ch];
            if (d == LONG) push_ev(cyc, ch, 2);
`ifdef BTN_AUTO_REPEAT_EN
            if (d > LONG && ((d - LONG) % REP) == 0) push_ev(cyc, ch, 3);
`endif
          end
        end
      end
    end
  end

  // Monitor: match every DUT pulse against the expected queue; flag leftovers
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        total++;
        if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} != '0) begin
          bad++;
          $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc,
                   {btn_level, btn_press, btn_release, btn_long, btn_repeat});
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
      end else begin
        for (int ch = 0; ch < N; ch++) begin
          for (int kind = 0; kind < 4; kind++) begin
            logic v;
            case (kind)
              0:       v = btn_press[ch];
              1:       v = btn_release[ch];
              2:       v = btn_long[ch];
              default: v = btn_repeat[ch];
            endcase
            if (v) begin
              int found;
              found = -1;
              for (int i = 0; i < exp_q.size(); i++)
                if (found < 0 && exp_q[i].cyc == cyc && exp_q[i].ch == ch &&
                    exp_q[i].kind == kind) found = i;
              total++;
              if (found < 0) begin
                bad++;
                $display("FAIL unexpected_%s cyc=%0d ch=%0d got=1 want=0",
                         kname[kind], cyc, ch);
              end else begin
                exp_q.delete(found);
              end
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          total++;
          bad++;
          $display("FAIL missing_%s cyc=%0d ch=%0d got=0 want=1",
                   kname[exp_q[0].kind], exp_q[0].cyc, exp_q[0].ch);
          void'(exp_q.pop_front());
        end
        for (int ch = 0; ch < N; ch++) begin
          total++;
          if (btn_level[ch] !== mlevel[ch]) begin
            bad++;
            $display("FAIL level cyc=%0d ch=%0d got=%b want=%b",
                     cyc, ch, btn_level[ch], mlevel[ch]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset must clear every output within the same cycle
  task automatic async_reset(input int hold);
    rst = 1'b1;
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} != '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0",
               {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    tick(hold);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = '1;
    tick(3);
    rst = 1'b0;
    tick(40);
    btn_in = '0;
    tick(20);

    // Bouncing press on channel 0 with 2-cycle glitches
    for (int i = 0; i < 5; i++) begin
      btn_in[0] = (i % 2 == 0);
      tick(2);
    end
    btn_in[0] = 1'b1;
    tick(40);
    btn_in[0] = 1'b0;
    tick(15);

    // Short pulse on channel 1 is discarded
    btn_in[1] = 1'b1;
    tick(3);
    btn_in[1] = 1'b0;
    tick(15);

    // Long hold on channel 2 through several repeat periods
    btn_in[2] = 1'b1;
    tick(SYNC + STABLE + 60);
    btn_in[2] = 1'b0;
    tick(30);

    // Channels 3 and 4 together, released 10 cycles apart
    btn_in[3] = 1'b1;
    btn_in[4] = 1'b1;
    tick(30);
    btn_in[3] = 1'b0;
    tick(10);
    btn_in[4] = 1'b0;
    tick(20);

    // Reset during a hold, button kept down afterwards
    btn_in[2] = 1'b1;
    tick(SYNC + STABLE + 22);
    async_reset(2);
    tick(40);
    btn_in[2] = 1'b0;
    tick(15);

    // Randomised segments: per channel steady, new level, or bouncing
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      int mode [N];
      len = $urandom_range(1, 50);
      for (int ch = 0; ch < N; ch++) begin
        mode[ch] = $urandom_range(0, 2);
        if (mode[ch] == 1) btn_in[ch] = $urandom_range(0, 1) != 0;
      end
      if (seg == 20) async_reset(2);
      for (int t = 0; t < len; t++) begin
        for (int ch = 0; ch < N; ch++)
          if (mode[ch] == 2 && $urandom_range(0, 2) == 0) btn_in[ch] = ~btn_in[ch];
        tick(1);
      end
    end

    btn_in = '0;
    tick(30);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
